dmem_sram: RTL and testbench

Parametrised single-port data memory for the NPC load/store path. A valid/ready request port accepts one read or write per cycle into an on-chip SRAM array, with per-byte write masking and a configurable read-pipeline latency. Every accepted request returns exactly one in-order response through a buffered valid/ready response port, with an address-window error flag. It replaces the fixed one-cycle, always-ready data memory behind the LSU.

---
 rtl/dmem_sram.sv | 169 ++++++++++++++++
 tb/tb_dmem_sram.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sram.sv
// Single-port data memory behind a valid/ready request port. Responses leave in
// acceptance order through a fixed-latency pipeline and a bypassable FIFO.
module dmem_sram #(
    parameter int          DATA_W     = 32,
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          LATENCY    = 1,
    parameter int          RSP_DEPTH  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_wen_i,
    input  logic [31:0]         req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wmask_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o
);
    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [32:0] WIN_BYTES = 33'(NB) << DEPTH_LOG2;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  reqFire, rspFire, inWin, wrEn, rdEn;
    logic [31:0]           offset;
    logic [DEPTH_LOG2-1:0] wordIdx;

    assign req_ready_o = rst_i | (cnt_q < CW'(RSP_DEPTH));
    assign reqFire     = req_valid_i & req_ready_o & ~rst_i;
    assign offset      = req_addr_i - BASE;
    assign inWin       = {1'b0, offset} < WIN_BYTES;
    assign wordIdx     = req_addr_i[DEPTH_LOG2+LB-1:LB];
    assign wrEn        = reqFire & inWin & req_wen_i;
    assign rdEn        = reqFire & inWin & ~req_wen_i;

    always_comb begin
        cnt_d = cnt_q;
        if (reqFire && !rspFire) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!reqFire && rspFire) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Array is never reset; stage 0 captures read data on the accept edge.
    logic [DATA_W-1:0] mem_q [WORDS];
    logic              s0Valid_q, s0Err_q;
    logic [DATA_W-1:0] s0Data_q;

    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            for (int b = 0; b < NB; b++) begin
                if (req_wmask_i[b]) begin
                    mem_q[wordIdx][8*b +: 8] <= req_wdata_i[8*b +: 8];
                end
            end
        end
        if (reqFire) begin
            s0Data_q <= rdEn ? mem_q[wordIdx] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0Valid_q <= 1'b0;
        end else begin
            s0Valid_q <= reqFire;
        end
        if (reqFire) begin
            s0Err_q <= ~inWin;
        end
    end

    logic              finValid, finErr;
    logic [DATA_W-1:0] finData;

    if (LATENCY == 1) begin : g_direct
        assign finValid = s0Valid_q;
        assign finErr   = s0Err_q;
        assign finData  = s0Data_q;
    end else begin : g_delay
        logic [LATENCY-2:0] dlyValid_q, dlyErr_q;
        logic [DATA_W-1:0]  dlyData_q [LATENCY-1];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                dlyValid_q <= '0;
            end else begin
                dlyValid_q[0] <= s0Valid_q;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    dlyValid_q[i] <= dlyValid_q[i-1];
                end
            end
            dlyErr_q[0]  <= s0Err_q;
            dlyData_q[0] <= s0Data_q;
            for (int i = 1; i < LATENCY - 1; i++) begin
                dlyErr_q[i]  <= dlyErr_q[i-1];
                dlyData_q[i] <= dlyData_q[i-1];
            end
        end

        assign finValid = dlyValid_q[LATENCY-2];
        assign finErr   = dlyErr_q[LATENCY-2];
        assign finData  = dlyData_q[LATENCY-2];
    end

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The outstanding limit guarantees the FIFO never overflows, so stages never stall.
    logic [DATA_W:0] fifo_q [RSP_DEPTH];
    logic [PW-1:0]   wrPtr_q, rdPtr_q;
    logic [CW-1:0]   fifoCnt_q;
    logic            fifoEmpty, push, pop;
    logic [DATA_W:0] head;

    assign fifoEmpty = (fifoCnt_q == '0);
    assign pop       = ~fifoEmpty & rsp_ready_i;
    assign push      = finValid & ~(fifoEmpty & rsp_ready_i);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wrPtr_q] <= {finErr, finData};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            fifoCnt_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= ptrInc(wrPtr_q);
            end
            if (pop) begin
                rdPtr_q <= ptrInc(rdPtr_q);
            end
            case ({push, pop})
                2'b10:   fifoCnt_q <= fifoCnt_q + CW'(1);
                2'b01:   fifoCnt_q <= fifoCnt_q - CW'(1);
                default: fifoCnt_q <= fifoCnt_q;
            endcase
        end
    end

    assign head        = fifoEmpty ? {finErr, finData} : fifo_q[rdPtr_q];
    assign rsp_valid_o = ~rst_i & (~fifoEmpty | finValid);
    assign rsp_rdata_o = rsp_valid_o ? head[DATA_W-1:0] : '0;
    assign rsp_err_o   = rsp_valid_o & head[DATA_W];
    assign rspFire     = rsp_valid_o & rsp_ready_i;

endmodule

// File: tb/tb_dmem_sram.sv
// Bench for dmem_sram: a LATENCY=1/RSP_DEPTH=2 instance and a LATENCY=3/RSP_DEPTH=4
// instance share one stimulus bus selected by 'sel'; responses are scoreboarded.
module tb_dmem_sram;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] WIN  = 32'h0000_4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        reqValid = 1'b0, reqWen = 1'b0, rspReady = 1'b1;
    logic [31:0] reqAddr = '0, reqWdata = '0;
    logic [3:0]  reqWmask = '0;

    logic        rdyA, vldA, errA, rdyB, vldB, errB;
    logic [31:0] dataA, dataB;
    logic        reqReady, rspValid, rspErr;
    logic [31:0] rspRdata;

    int          checks = 0, failures = 0, cycleNo = 0;
    logic [32:0] sb [$];
    logic [31:0] model [int unsigned];

    always #5 clk = ~clk;

    dmem_sram #(.DATA_W(32), .DEPTH_LOG2(12), .BASE(BASE), .LATENCY(1), .RSP_DEPTH(2)) uA (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid & ~sel), .req_ready_o(rdyA), .req_wen_i(reqWen),
        .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .req_wmask_i(reqWmask),
        .rsp_valid_o(vldA), .rsp_ready_i(sel | rspReady), .rsp_rdata_o(dataA), .rsp_err_o(errA)
    );

    dmem_sram #(.DATA_W(32), .DEPTH_LOG2(12), .BASE(BASE), .LATENCY(3), .RSP_DEPTH(4)) uB (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid & sel), .req_ready_o(rdyB), .req_wen_i(reqWen),
        .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .req_wmask_i(reqWmask),
        .rsp_valid_o(vldB), .rsp_ready_i(~sel | rspReady), .rsp_rdata_o(dataB), .rsp_err_o(errB)
    );

    assign reqReady = sel ? rdyB : rdyA;
    assign rspValid = sel ? vldB : vldA;
    assign rspErr   = sel ? errB : errA;
    assign rspRdata = sel ? dataB : dataA;

    // One bus cycle: drive at negedge, sample 1ns later, keep model and scoreboard in step.
    task automatic cyc(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic rr, input logic r,
                       output logic rf, output logic sf, output logic rdy, output logic vld,
                       output logic [32:0] obs, output logic [32:0] exp);
        logic [31:0] word;
        @(negedge clk);
        rst = r; reqValid = v; reqWen = w; reqAddr = a; reqWdata = d; reqWmask = m; rspReady = rr;
        #1;
        rdy = reqReady;
        vld = rspValid;
        obs = {rspErr, rspRdata};
        rf  = v & rdy & ~r;
        sf  = vld & rr & ~r;
        exp = 'x;
        if (r) begin
            sb.delete();
        end else if (sf && sb.size() > 0) begin
            exp = sb.pop_front();
        end
        if (rf) begin
            if ((a - BASE) >= WIN) begin
                sb.push_back({1'b1, 32'h0});
            end else if (w) begin
                word = model.exists(a[13:2]) ? model[a[13:2]] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) word[8*b +: 8] = d[8*b +: 8];
                end
                model[a[13:2]] = word;
                sb.push_back(33'h0);
            end else begin
                sb.push_back({1'b0, model[a[13:2]]});
            end
        end
        cycleNo++;
    endtask

    task automatic test_reset();
        logic rf, sf, rdy, vld;
        logic [32:0] obs, exp;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 2; i++) begin
                cyc(0, 0, 0, 0, 0, 1, 1, rf, sf, rdy, vld, obs, exp);
                checks++;
                if ({rdy, vld, obs} !== {1'b1, 1'b0, 33'h0}) begin
                    failures++;
                    $display("[TB] FAIL reset_outputs dut=%0d got rdy=%b vld=%b rsp=%h exp rdy=1 vld=0 rsp=0", s, rdy, vld, obs);
                end
            end
            cyc(0, 0, 0, 0, 0, 1, 0, rf, sf, rdy, vld, obs, exp);
            checks++;
            if ({rdy, vld, obs} !== {1'b1, 1'b0, 33'h0}) begin
                failures++;
                $display("[TB] FAIL post_reset_outputs dut=%0d got rdy=%b vld=%b rsp=%h exp rdy=1 vld=0 rsp=0", s, rdy, vld, obs);
            end
        end
    endtask

    task automatic test_basic();
        logic rf, sf, rdy, vld;
        logic [32:0] obs, exp;
        sel = 1'b0;
        cyc(1, 1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, rf, sf, rdy, vld, obs, exp);
        checks++;
        if (rf !== 1'b1) begin failures++; $display("[TB] FAIL basic_wr_accept got=%b exp=1", rf); end
        cyc(1, 0, BASE + 32'h10, 0, 0, 1, 0, rf, sf, rdy, vld, obs, exp);
        checks++;
        if (rf !== 1'b1) begin failures++; $display("[TB] FAIL basic_rd_accept got=%b exp=1", rf); end
        checks++;
        if ({sf, obs} !== {1'b1, exp}) begin
            failures++; $display("[TB] FAIL basic_wr_rsp got fire=%b rsp=%h exp fire=1 rsp=%h", sf, obs, exp);
        end
        cyc(0, 0, 0, 0, 0, 1, 0, rf, sf, rdy, vld, obs, exp);
        checks++;
        if ({sf, obs} !== {1'b1, 33'h0_DEADBEEF}) begin
            failures++; $display("[TB] FAIL basic_rd_rsp got fire=%b rsp=%h exp fire=1 rsp=0deadbeef", sf, obs);
        end
        cyc(0, 0, 0, 0, 0, 1, 0, rf, sf, rdy, vld, obs, exp);
        checks++;
        if ({vld, obs} !== 34'h0) begin
            failures++; $display("[TB] FAIL basic_idle got vld=%b rsp=%h exp vld=0 rsp=0", vld, obs);
        end
    endtask

    task automatic test_mask();
        logic rf, sf, rdy, vld;
        logic [32:0] obs, exp;
        logic [31:0] dat [3];
        logic [3:0]  msk [3];
        logic        wen [3];
        int          k, got;
        dat = '{32'h11223344, 32'hAABBCCDD, 32'h0};
        msk = '{4'hF, 4'b0101, 4'h0};
        wen = '{1'b1, 1'b1, 1'b0};
        sel = 1'b0; k = 0; got = 0;
        for (int i = 0; i < 20 && (k < 3 || sb.size() > 0); i++) begin
            cyc(k < 3, wen[(k < 3) ? k : 2], BASE + 32'h20, dat[(k < 3) ? k : 2], msk[(k < 3) ? k : 2], 1, 0,
                rf, sf, rdy, vld, obs, exp);
            if (rf) k++;
            if (sf) begin
                got++;
                checks++;
                if (obs !== exp) begin failures++; $display("[TB] FAIL mask_rsp got=%h exp=%h", obs, exp); end
                if (got == 3) begin
                    checks++;
                    if (obs !== 33'h0_11BB33DD) begin
                        failures++; $display("[TB] FAIL mask_merge got=%h exp=011bb33dd", obs);
                    end
                end
            end
        end
        checks++;
        if (got !== 3) begin failures++; $display("[TB] FAIL mask_count got=%0d exp=3", got); end
    endtask

    task automatic test_back_to_back();
        logic rf, sf, rdy, vld;
        logic [32:0] obs, exp;
        int issued, got, firstAcc, firstRsp, lastRsp, gaps, stalls;
        sel = 1'b1;
        issued = 0;
        for (int i = 0; i < 40 && (issued < 16 || sb.size() > 0); i++) begin
            cyc(issued < 16, 1, BASE + 32'h100 + 32'(issued * 4),
                32'hA500_0000 ^ (32'(issued) * 32'h0101_0101), 4'hF, 1, 0, rf, sf, rdy, vld, obs, exp);
            if (rf) issued++;
            if (sf) begin
                checks++;
                if (obs !== exp) begin failures++; $display("[TB] FAIL b2b_preload_rsp got=%h exp=%h", obs, exp); end
            end
        end
        issued = 0; got = 0; gaps = 0; stalls = 0; firstAcc = -1; firstRsp = -1; lastRsp = -1;
        for (int i = 0; i < 40 && (issued < 16 || sb.size() > 0); i++) begin
            cyc(issued < 16, 0, BASE + 32'h100 + 32'(issued * 4), 0, 0, 1, 0, rf, sf, rdy, vld, obs, exp);
            if (issued < 16 && !rf) stalls++;
            if (rf) begin
                if (issued == 0) firstAcc = cycleNo;
                issued++;
            end
            if (sf) begin
                checks++;
                if (obs !== exp) begin failures++; $display("[TB] FAIL b2b_rsp n=%0d got=%h exp=%h", got, obs, exp); end
                if (got == 0) firstRsp = cycleNo;
                else if (cycleNo != lastRsp + 1) gaps++;
                lastRsp = cycleNo;
                got++;
            end
        end
        checks++;
        if (stalls !== 0) begin failures++; $display("[TB] FAIL b2b_stalls got=%0d exp=0", stalls); end
        checks++;
        if (got !== 16) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=16", got); end
        checks++;
        if (firstRsp - firstAcc !== 3) begin
            failures++; $display("[TB] FAIL b2b_latency got=%0d exp=3", firstRsp - firstAcc);
        end
        checks++;
        if (gaps !== 0) begin failures++; $display("[TB] FAIL b2b_gaps got=%0d exp=0", gaps); end
    endtask

    task automatic test_backpressure();
        logic rf, sf, rdy, vld;
        logic [32:0] obs, exp, held;
        sel = 1'b0;
        cyc(1, 0, BASE + 32'h10, 0, 0, 0, 0, rf, sf, rdy, vld, obs, exp);
        checks++;
        if (rf !== 1'b1) begin failures++; $display("[TB] FAIL bp_accept0 got=%b exp=1", rf); end
        cyc(1, 0, BASE + 32'h20, 0, 0, 0, 0, rf, sf, rdy, vld, obs, exp);
        checks++;
        if (rf !== 1'b1) begin failures++; $display("[TB] FAIL bp_accept1 got=%b exp=1", rf); end
        held = obs;
        checks++;
        if ({vld, obs} !== {1'b1, 33'h0_DEADBEEF}) begin
            failures++; $display("[TB] FAIL bp_first_rsp got vld=%b rsp=%h exp vld=1 rsp=0deadbeef", vld, obs);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, BASE + 32'h10, 0, 0, 0, 0, rf, sf, rdy, vld, obs, exp);
            checks++;
            if (rdy !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_low got=%b exp=0", rdy); end
            checks++;
            if ({vld, obs} !== {1'b1, held}) begin
                failures++; $display("[TB] FAIL bp_stable got vld=%b rsp=%h exp vld=1 rsp=%h", vld, obs, held);
            end
        end
        cyc(1, 0, BASE + 32'h10, 0, 0, 1, 0, rf, sf, rdy, vld, obs, exp);
        checks++;
        if ({sf, rf} !== 2'b10) begin failures++; $display("[TB] FAIL bp_release got fire=%b acc=%b exp fire=1 acc=0", sf, rf); end
        checks++;
        if (obs !== exp) begin failures++; $display("[TB] FAIL bp_rsp0 got=%h exp=%h", obs, exp); end
        cyc(1, 0, BASE + 32'h10, 0, 0, 1, 0, rf, sf, rdy, vld, obs, exp);
        checks++;
        if (rf !== 1'b1) begin failures++; $display("[TB] FAIL bp_third_accept got=%b exp=1", rf); end
        checks++;
        if ({sf, obs} !== {1'b1, 33'h0_11BB33DD}) begin
            failures++; $display("[TB] FAIL bp_rsp1 got fire=%b rsp=%h exp fire=1 rsp=011bb33dd", sf, obs);
        end
        for (int i = 0; i < 6 && sb.size() > 0; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, rf, sf, rdy, vld, obs, exp);
            if (sf) begin
                checks++;
                if (obs !== exp) begin failures++; $display("[TB] FAIL bp_drain_rsp got=%h exp=%h", obs, exp); end
            end
        end
        checks++;
        if (sb.size() !== 0) begin failures++; $display("[TB] FAIL bp_drain got=%0d pending exp=0", sb.size()); end
    endtask

    task automatic test_window();
        logic rf, sf, rdy, vld;
        logic [32:0] obs, exp;
        logic [31:0] adr [4];
        logic [31:0] dat [4];
        logic        wen [4];
        int          k, got;
        adr = '{BASE, BASE - 32'h4, BASE + WIN, BASE};
        dat = '{32'hCAFEF00D, 32'h0, 32'hFFFFFFFF, 32'h0};
        wen = '{1'b1, 1'b0, 1'b1, 1'b0};
        sel = 1'b0; k = 0; got = 0;
        for (int i = 0; i < 20 && (k < 4 || sb.size() > 0); i++) begin
            cyc(k < 4, wen[(k < 4) ? k : 3], adr[(k < 4) ? k : 3], dat[(k < 4) ? k : 3], 4'hF, 1, 0,
                rf, sf, rdy, vld, obs, exp);
            if (rf) k++;
            if (sf) begin
                got++;
                checks++;
                if (obs !== exp) begin failures++; $display("[TB] FAIL win_rsp got=%h exp=%h", obs, exp); end
                if (got == 2 || got == 3) begin
                    checks++;
                    if (obs !== {1'b1, 32'h0}) begin failures++; $display("[TB] FAIL win_err got=%h exp=100000000", obs); end
                end
                if (got == 4) begin
                    checks++;
                    if (obs !== 33'h0_CAFEF00D) begin failures++; $display("[TB] FAIL win_unchanged got=%h exp=0cafef00d", obs); end
                end
            end
        end
        checks++;
        if (got !== 4) begin failures++; $display("[TB] FAIL win_count got=%0d exp=4", got); end
    endtask

    task automatic test_reset_midflight();
        logic rf, sf, rdy, vld;
        logic [32:0] obs, exp;
        int vldSeen, notRdy, accepted, got;
        sel = 1'b1;
        cyc(1, 1, BASE + 32'h40, 32'h5A5A5A5A, 4'hF, 1, 0, rf, sf, rdy, vld, obs, exp);
        checks++;
        if (rf !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_wr_accept got=%b exp=1", rf); end
        cyc(1, 0, BASE + 32'h40, 0, 0, 1, 0, rf, sf, rdy, vld, obs, exp);
        checks++;
        if (rf !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_rd_accept got=%b exp=1", rf); end
        cyc(0, 0, 0, 0, 0, 1, 1, rf, sf, rdy, vld, obs, exp);
        vldSeen = 0; notRdy = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, rf, sf, rdy, vld, obs, exp);
            if (vld) vldSeen++;
            if (!rdy) notRdy++;
        end
        checks++;
        if (vldSeen !== 0) begin failures++; $display("[TB] FAIL rstmid_no_rsp got=%0d responses exp=0", vldSeen); end
        checks++;
        if (notRdy !== 0) begin failures++; $display("[TB] FAIL rstmid_ready got=%0d low cycles exp=0", notRdy); end
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, BASE + 32'h40, 0, 0, 0, 0, rf, sf, rdy, vld, obs, exp);
            if (rf) accepted++;
        end
        checks++;
        if (accepted !== 4) begin failures++; $display("[TB] FAIL rstmid_cnt_cleared got=%0d accepts exp=4", accepted); end
        got = 0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, rf, sf, rdy, vld, obs, exp);
            if (sf) begin
                got++;
                checks++;
                if (obs !== 33'h0_5A5A5A5A || obs !== exp) begin
                    failures++; $display("[TB] FAIL rstmid_read got=%h exp=05a5a5a5a", obs);
                end
            end
        end
        checks++;
        if (got !== 4) begin failures++; $display("[TB] FAIL rstmid_count got=%0d exp=4", got); end
    endtask

    initial begin
        $display("[TB] dmem_sram bench start");
        test_reset();
        test_basic();
        test_mask();
        test_back_to_back();
        test_backpressure();
        test_window();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
